tm_batch_inference: RTL and testbench

TM_BATCH_INFERENCE -- requirements
Module: tm_batch_inference

---
 rtl/tm_inference_pkg.sv | 24 ++
 rtl/tm_clause_eval.sv | 24 ++
 rtl/tm_batch_inference.sv | 194 +++++++++++++++++++
 tb/tb_tm_batch_inference.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tm_inference_pkg.sv
// Shared types and width helpers for the Tsetlin-machine batch inference block.
// Width helpers are used by the top-level and its sub-modules so that
// every file agrees on class-index and class-sum widths.
package tm_inference_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_CMP   = 2'd2,
    ST_DONE  = 2'd3
  } tm_state_e;

  // Class index width; a single class still needs one bit.
  function automatic int class_idx_w(input int num_classes);
    return (num_classes > 1) ? $clog2(num_classes) : 1;
  endfunction

  // Signed class-sum width: magnitude up to CLAUSES_PER_CLASS/2, plus sign
  // and one bit of headroom so accumulation can never wrap.
  function automatic int sum_w(input int clauses_per_class);
    return $clog2(clauses_per_class) + 2;
  endfunction

endpackage

// File: rtl/tm_clause_eval.sv
// One image's clause evaluation: AND of every included literal.
// Low half of the mask includes x, high half includes ~x.
// An empty mask evaluates to 0 rather than to a vacuous 1.
module tm_clause_eval
  import tm_inference_pkg::*;
#(
  parameter int NUM_LITERALS = 9
) (
  input  logic [2*NUM_LITERALS-1:0] clause_mask,
  input  logic [NUM_LITERALS-1:0]   literals,
  output logic                      clause_out
);

  logic [NUM_LITERALS-1:0] pos_ok;
  logic [NUM_LITERALS-1:0] neg_ok;

  // Each literal position passes if it is not included or its value matches.
  always_comb begin
    pos_ok     = ~clause_mask[NUM_LITERALS-1:0] | literals;
    neg_ok     = ~clause_mask[2*NUM_LITERALS-1:NUM_LITERALS] | ~literals;
    clause_out = (|clause_mask) & (&pos_ok) & (&neg_ok);
  end

endmodule

// File: rtl/tm_batch_inference.sv
// Batch Tsetlin-machine inference: streams class-major clause masks,
// evaluates every clause on NUM_IMAGES images in parallel, accumulates
// signed per-class votes, clamps them to +/-THRESHOLD and keeps a running
// argmax per image (ties keep the lower class index).
// Optional feature macro: TM_CLASS_SUM_OUT_EN adds class_sum_out carrying
// every clamped class sum of the last run.
module tm_batch_inference
  import tm_inference_pkg::*;
#(
  parameter int NUM_IMAGES        = 8,
  parameter int NUM_CLASSES       = 4,
  parameter int CLAUSES_PER_CLASS = 16,
  parameter int NUM_LITERALS      = 9,
  parameter int THRESHOLD         = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [NUM_IMAGES*NUM_LITERALS-1:0]   literals_in,
  input  logic                                 clause_valid,
  input  logic [2*NUM_LITERALS-1:0]            clause_mask,
  output logic                                 clause_ready,
  output logic                                 busy,
  output logic                                 result_valid,
`ifdef TM_CLASS_SUM_OUT_EN
  output logic [NUM_IMAGES*NUM_CLASSES*sum_w(CLAUSES_PER_CLASS)-1:0] class_sum_out,
`endif
  output logic [NUM_IMAGES*class_idx_w(NUM_CLASSES)-1:0] predicted_class
);

  localparam int CW = class_idx_w(NUM_CLASSES);
  localparam int SW = sum_w(CLAUSES_PER_CLASS);
  localparam int BW = $clog2(CLAUSES_PER_CLASS);
  localparam logic signed [SW-1:0] T_POS = SW'(THRESHOLD);
  localparam logic signed [SW-1:0] T_NEG = -T_POS;

  tm_state_e state_q, state_d;
  logic [CW-1:0] class_q, class_d;
  logic [BW-1:0] beat_q, beat_d;
  logic signed [SW-1:0] sum_q [NUM_IMAGES];
  logic signed [SW-1:0] sum_d [NUM_IMAGES];
  logic signed [SW-1:0] best_sum_q [NUM_IMAGES];
  logic signed [SW-1:0] best_sum_d [NUM_IMAGES];
  logic [CW-1:0] best_idx_q [NUM_IMAGES];
  logic [CW-1:0] best_idx_d [NUM_IMAGES];
  logic [NUM_IMAGES*CW-1:0] pred_q, pred_d;
  logic [NUM_IMAGES*CW-1:0] best_packed;
  logic signed [SW-1:0] clamped [NUM_IMAGES];
  logic [NUM_IMAGES-1:0] clause_fire;
`ifdef TM_CLASS_SUM_OUT_EN
  logic [NUM_IMAGES*NUM_CLASSES*SW-1:0] csum_q, csum_d;
`endif

  for (genvar g = 0; g < NUM_IMAGES; g++) begin : g_eval
    tm_clause_eval #(
      .NUM_LITERALS(NUM_LITERALS)
    ) u_eval (
      .clause_mask(clause_mask),
      .literals   (literals_in[g*NUM_LITERALS +: NUM_LITERALS]),
      .clause_out (clause_fire[g])
    );
  end

  // Clamp each running sum to the threshold window and pack the best indices.
  always_comb begin
    best_packed = '0;
    for (int i = 0; i < NUM_IMAGES; i++) begin
      clamped[i] = sum_q[i];
      if (sum_q[i] > T_POS) begin
        clamped[i] = T_POS;
      end else if (sum_q[i] < T_NEG) begin
        clamped[i] = T_NEG;
      end
      best_packed[i*CW +: CW] = best_idx_q[i];
    end
  end

  // Next-state and datapath updates; abort outranks any beat or compare.
  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    beat_d     = beat_q;
    sum_d      = sum_q;
    best_sum_d = best_sum_q;
    best_idx_d = best_idx_q;
    pred_d     = pred_q;
`ifdef TM_CLASS_SUM_OUT_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          class_d = '0;
          beat_d  = '0;
          for (int i = 0; i < NUM_IMAGES; i++) begin
            sum_d[i]      = '0;
            best_sum_d[i] = '0;
            best_idx_d[i] = '0;
          end
        end
      end
      ST_ACCUM: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (clause_valid) begin
          for (int i = 0; i < NUM_IMAGES; i++) begin
            if (clause_fire[i]) begin
              sum_d[i] = beat_q[0] ? (sum_q[i] - SW'(1)) : (sum_q[i] + SW'(1));
            end
          end
          if (beat_q == BW'(CLAUSES_PER_CLASS - 1)) begin
            beat_d  = '0;
            state_d = ST_CMP;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      ST_CMP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          for (int i = 0; i < NUM_IMAGES; i++) begin
            if ((class_q == '0) || (clamped[i] > best_sum_q[i])) begin
              best_sum_d[i] = clamped[i];
              best_idx_d[i] = class_q;
            end
            sum_d[i] = '0;
`ifdef TM_CLASS_SUM_OUT_EN
            csum_d[(i*NUM_CLASSES + int'(class_q))*SW +: SW] = clamped[i];
`endif
          end
          if (class_q == CW'(NUM_CLASSES - 1)) begin
            state_d = ST_DONE;
          end else begin
            class_d = class_q + CW'(1);
            state_d = ST_ACCUM;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!abort) begin
          pred_d = best_packed;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      class_q <= '0;
      beat_q  <= '0;
      pred_q  <= '0;
      for (int i = 0; i < NUM_IMAGES; i++) begin
        sum_q[i]      <= '0;
        best_sum_q[i] <= '0;
        best_idx_q[i] <= '0;
      end
`ifdef TM_CLASS_SUM_OUT_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      class_q    <= class_d;
      beat_q     <= beat_d;
      pred_q     <= pred_d;
      sum_q      <= sum_d;
      best_sum_q <= best_sum_d;
      best_idx_q <= best_idx_d;
`ifdef TM_CLASS_SUM_OUT_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Status outputs; predictions show the fresh argmax during the DONE pulse.
  always_comb begin
    clause_ready    = (state_q == ST_ACCUM);
    busy            = (state_q != ST_IDLE);
    result_valid    = (state_q == ST_DONE) && !abort;
    predicted_class = result_valid ? best_packed : pred_q;
  end

`ifdef TM_CLASS_SUM_OUT_EN
  assign class_sum_out = csum_q;
`endif

endmodule

// File: tb/tb_tm_batch_inference.sv
// Directed bench for tm_batch_inference (THRESHOLD overridden to 4).
// Covers reset values, empty-mask runs, single-class wins, clamping and
// cancellation, stalls, start-while-busy, abort and mid-run reset.
// Honours TM_CLASS_SUM_OUT_EN when connecting the optional port.
module tb_tm_batch_inference;

  logic         clock;
  logic         reset;
  logic         start;
  logic         abort;
  logic [71:0]  literals_in;
  logic         clause_valid;
  logic [17:0]  clause_mask;
  logic         clause_ready;
  logic         busy;
  logic         result_valid;
  logic [15:0]  predicted_class;
`ifdef TM_CLASS_SUM_OUT_EN
  logic [191:0] class_sum_out;
`endif

  int checks = 0;
  int errors = 0;
  logic [17:0] maskTab [4][16];
  logic [8:0]  litImg [8];
  int edges;
  int stalls;
  bit sawValid;

  tm_batch_inference #(
    .NUM_IMAGES(8),
    .NUM_CLASSES(4),
    .CLAUSES_PER_CLASS(16),
    .NUM_LITERALS(9),
    .THRESHOLD(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .abort(abort),
    .literals_in(literals_in),
    .clause_valid(clause_valid),
    .clause_mask(clause_mask),
    .clause_ready(clause_ready),
    .busy(busy),
    .result_valid(result_valid),
`ifdef TM_CLASS_SUM_OUT_EN
    .class_sum_out(class_sum_out),
`endif
    .predicted_class(predicted_class)
  );

  // 10-time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyLiterals();
    for (int i = 0; i < 8; i++) literals_in[i*9 +: 9] = litImg[i];
  endtask

  task automatic clearMasks();
    for (int c = 0; c < 4; c++)
      for (int b = 0; b < 16; b++) maskTab[c][b] = '0;
  endtask

  // Class 2 even clauses include x0 only; image 3 alone has x0 set.
  task automatic setupPassB();
    clearMasks();
    for (int b = 0; b < 16; b += 2) maskTab[2][b] = 18'h00001;
    for (int i = 0; i < 8; i++) litImg[i] = 9'h1FE;
    litImg[3] = 9'h1FF;
    applyLiterals();
  endtask

  // Class 1: all 16 clauses on x1 (cancel to 0). Class 2: five even clauses
  // on x2 (+5 -> 4). Class 3: eight even clauses on x3 (+8 -> 4).
  task automatic setupPassC();
    clearMasks();
    for (int b = 0; b < 16; b++) maskTab[1][b] = 18'h00002;
    for (int b = 0; b < 10; b += 2) maskTab[2][b] = 18'h00004;
    for (int b = 0; b < 16; b += 2) maskTab[3][b] = 18'h00008;
    litImg[0] = 9'h000; litImg[1] = 9'h002; litImg[2] = 9'h004; litImg[3] = 9'h00C;
    litImg[4] = 9'h008; litImg[5] = 9'h00A; litImg[6] = 9'h1FF; litImg[7] = 9'h001;
    applyLiterals();
  endtask

  // Starts a run and feeds nBeats beats, one idle cycle per compare state.
  task automatic applyStimulus(input int nBeats, input int stallPct, input bit holdStart,
                               output int nEdges, output int nStalls);
    int run;
    nEdges = 0;
    nStalls = 0;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    nEdges = 1;
    #1;
    if (!holdStart) start = 1'b0;
    for (int k = 0; k < nBeats; k++) begin
      run = 0;
      while (stallPct > 0 && run < 3 && $urandom_range(99, 0) < stallPct) begin
        clause_valid = 1'b0;
        clause_mask = 18'h3FFFF;
        @(posedge clock);
        nEdges++;
        nStalls++;
        run++;
        #1;
      end
      clause_valid = 1'b1;
      clause_mask = maskTab[k/16][k%16];
      @(posedge clock);
      nEdges++;
      #1;
      clause_valid = 1'b0;
      clause_mask = '0;
      if (k % 16 == 15) begin
        @(posedge clock);
        nEdges++;
        #1;
      end
    end
    start = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic [15:0] expPred);
    checkOutput({tag, "_valid"}, result_valid, 1'b1);
    checkOutput({tag, "_pred"}, predicted_class, expPred);
    @(posedge clock);
    #1;
    checkOutput({tag, "_valid_drop"}, result_valid, 1'b0);
    checkOutput({tag, "_busy_idle"}, busy, 1'b0);
    checkOutput({tag, "_pred_hold"}, predicted_class, expPred);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    clause_valid = 1'b0;
    clause_mask = '0;
    literals_in = '0;

    #12;
    checkOutput("rst_pred", predicted_class, 16'h0000);
    checkOutput("rst_valid", result_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ready", clause_ready, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    $display("[TB] empty-mask run");
    clearMasks();
    for (int i = 0; i < 8; i++) litImg[i] = 9'($urandom);
    applyLiterals();
    applyStimulus(64, 0, 1'b0, edges, stalls);
    checkResult("zero", 16'h0000);

    $display("[TB] single class 2 winner");
    setupPassB();
    applyStimulus(64, 0, 1'b0, edges, stalls);
    checkResult("passB", 16'h0080);

    $display("[TB] clamp and cancel run with stalls and start held high");
    setupPassC();
    applyStimulus(64, 30, 1'b1, edges, stalls);
    checkOutput("stall_latency", edges, 69 + stalls);
    checkResult("passC", 16'h2FA0);

    $display("[TB] abort at beat 20");
    setupPassB();
    applyStimulus(20, 0, 1'b0, edges, stalls);
    clause_valid = 1'b1;
    clause_mask = maskTab[1][4];
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    clause_valid = 1'b0;
    clause_mask = '0;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_ready", clause_ready, 1'b0);
    checkOutput("abort_valid", result_valid, 1'b0);
    checkOutput("abort_pred", predicted_class, 16'h2FA0);
    sawValid = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clock);
      #1;
      if (result_valid !== 1'b0) sawValid = 1'b1;
    end
    checkOutput("abort_no_result", sawValid, 1'b0);

    $display("[TB] reset at beat 30");
    setupPassC();
    applyStimulus(30, 0, 1'b0, edges, stalls);
    reset = 1'b0;
    #1;
    checkOutput("midrst_pred", predicted_class, 16'h0000);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_ready", clause_ready, 1'b0);
    checkOutput("midrst_valid", result_valid, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    $display("[TB] fresh run after reset");
    setupPassB();
    applyStimulus(64, 0, 1'b0, edges, stalls);
    checkResult("fresh", 16'h0080);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
